hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: NUM_GPR, 32, number of tracked general purpose registers (index width = 5).
REQ-002 Parameter: MAX_LAT, 7, largest fixed writeback latency in cycles (counter width = 3).
REQ-003 Port: clk  input  1  clock; the block has one clock and every flop is rising-edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: issue  input  1  decode issues an instruction this cycle.
REQ-006 Port: issue_dst_valid, issue_dst  input  1, 5  issued instruction writes GPR issue_dst.
REQ-007 Port: issue_lat  input  3  fixed latency 1..MAX_LAT; 0 means variable latency (load), completed by ls_wb.
REQ-008 Port: src_valid[3], src_idx[3]  input  3x1, 3x5  source operands (ra, rb, rt) of the instruction in decode.
REQ-009 Port: dst_valid, dst_idx  input  1, 5  destination of the instruction in decode (WAW check).
REQ-010 Port: ls_wb, ls_wb_idx  input  1, 5  load/store unit writes back a variable-latency result.
REQ-011 Port: flush  input  1  pipeline flush; cancels fixed-latency pending entries.
REQ-012 Port: hold_data  output  1  decode must stall; drives the decode control hold_data input.
REQ-013 Port: loads_pending  output  1  at least one variable-latency entry is outstanding.

Function
REQ-014 Each GPR has a 3-bit down-counter cnt[i] and a 1-bit flag ld[i]; GPR i is busy when cnt[i]!=0 or ld[i]=1.
REQ-015 Accepted issue = issue & issue_dst_valid & !hold_data; issue while hold_data=1 is ignored.
REQ-016 On an accepted issue with issue_lat!=0, cnt[issue_dst] loads issue_lat at the next edge; with issue_lat=0, ld[issue_dst] sets at the next edge.
REQ-017 Every nonzero cnt[i] not being loaded decrements by 1 per cycle and saturates at 0.
REQ-018 ls_wb clears ld[ls_wb_idx] at the next edge; ls_wb to a non-pending index has no effect.
REQ-019 ls_wb and an accepted variable-latency issue to the same index in the same cycle: ld stays set (issue wins).
REQ-020 hold_data is combinational: 1 when any src_valid[k] hits a busy GPR, or dst_valid hits a busy GPR.
REQ-021 flush clears all cnt[i] at the next edge and has priority over a same-cycle issue; ld[i] is unaffected.
REQ-022 loads_pending = OR of all ld[i], registered-state derived, no input path.
REQ-023 Maximum stall caused by a fixed-latency producer = issue_lat cycles (consumer issues on cycle issue_lat after producer).

Reset
REQ-024 reset clears all cnt[i] and ld[i] at the next edge; hold_data=0 and loads_pending=0 in the cycle after reset is sampled high.
REQ-025 reset has priority over issue, ls_wb and flush; reset mid-operation discards all pending entries.

Configuration
REQ-026 Macro HAZARD_BYPASS_EN: when defined, a GPR with cnt[i]=1 and ld[i]=0 is not busy (result forwarded), so a latency-L producer stalls a consumer for L-1 cycles.
REQ-027 Without HAZARD_BYPASS_EN, REQ-020 applies unmodified and the full latency is stalled.

Structure
REQ-028 Reg_index (5-bit) and Lat_count (3-bit) typedefs and constant MAX_LAT default belong in Pu_types.
REQ-029 One sub-module scoreboard_entry (one cnt/ld pair plus busy output) is instantiated NUM_GPR times via generate.

Verification
REQ-030 Issue r5 lat=3, then decode src_idx[0]=5 -> hold_data=1 for 3 cycles, 0 on 4th (2 cycles with HAZARD_BYPASS_EN).
REQ-031 Issue r7 lat=0, read r7 -> hold_data stays 1 until ls_wb idx=7, 0 the cycle after; loads_pending 1->0.
REQ-032 Issue r3 lat=5, flush on next cycle -> read r3 not held one cycle after flush; ld entries survive.
REQ-033 ls_wb idx=9 and issue r9 lat=0 same cycle -> ld[9]=1, loads_pending=1.
REQ-034 issue r4 with hold_data=1 (src r2 busy) -> r4 not marked busy.
REQ-035 Reset asserted with r1 cnt=4 and r2 ld=1 -> all clear, hold_data=0, loads_pending=0 after one edge.

Source files
------------

// File: rtl/pu_types.sv
// Shared processing-unit types for the hazard scoreboard: register index,
// latency counter and default sizing constants.
package pu_types;

    localparam int NUM_GPR_DEFAULT = 32;
    localparam int MAX_LAT_DEFAULT = 7;
    localparam int REG_IDX_W       = 5;
    localparam int LAT_W           = 3;

    typedef logic [REG_IDX_W-1:0] reg_index;
    typedef logic [LAT_W-1:0]     lat_count;

    // A zero latency marks a load whose completion arrives later via ls_wb.
    function automatic logic lat_is_variable(input lat_count lat);
        return lat == '0;
    endfunction

    // Keeps a requested latency within the largest latency the pipe supports.
    function automatic lat_count clamp_lat(input lat_count lat, input int max_lat);
        if (int'(lat) > max_lat) begin
            return lat_count'(max_lat);
        end
        return lat;
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One GPR's pending-write tracker: a fixed-latency down-counter plus a
// variable-latency (load) flag. Forwarding of the final cycle: HAZARD_BYPASS_EN.
module scoreboard_entry
    import pu_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush_i,
    input  logic     load_cnt_i,
    input  lat_count load_val_i,
    input  logic     set_ld_i,
    input  logic     clr_ld_i,
    output logic     busy_o,
    output logic     ld_o
);

    lat_count cnt_q, cnt_d;
    logic     ld_q, ld_d;

    // Flush cancels the fixed-latency result even if it is being loaded now.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (load_cnt_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - lat_count'(1);
        end
    end

    // A new load to this register outranks a writeback of the older one.
    always_comb begin
        ld_d = ld_q;
        if (set_ld_i) begin
            ld_d = 1'b1;
        end else if (clr_ld_i) begin
            ld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ld_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

`ifdef HAZARD_BYPASS_EN
    // In its last cycle the result is forwarded, so the consumer may proceed.
    assign busy_o = ld_q | (cnt_q > lat_count'(1));
`else
    assign busy_o = ld_q | (cnt_q != '0);
`endif

    assign ld_o = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// GPR hazard scoreboard: tracks in-flight writes and stalls decode on RAW/WAW
// hazards. Optional result forwarding in the last cycle: HAZARD_BYPASS_EN.
module hazard_scoreboard
    import pu_types::*;
#(
    parameter int NUM_GPR = NUM_GPR_DEFAULT,
    parameter int MAX_LAT = MAX_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic       issue_dst_valid,
    input  reg_index   issue_dst,
    input  lat_count   issue_lat,
    input  logic [2:0] src_valid,
    input  reg_index   src_idx [3],
    input  logic       dst_valid,
    input  reg_index   dst_idx,
    input  logic       ls_wb,
    input  reg_index   ls_wb_idx,
    input  logic       flush,
    output logic       hold_data,
    output logic       loads_pending
);

    logic [NUM_GPR-1:0] busy_vec;
    logic [NUM_GPR-1:0] ld_vec;
    logic               issue_accept;
    logic               issue_var;
    lat_count           issue_lat_eff;

    // A stalled instruction never reaches execute, so it must not claim its dst.
    assign issue_accept  = issue & issue_dst_valid & ~hold_data;
    assign issue_var     = lat_is_variable(issue_lat);
    assign issue_lat_eff = clamp_lat(issue_lat, MAX_LAT);

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_entry
        logic hit_issue;
        logic hit_wb;

        assign hit_issue = issue_accept & (issue_dst == reg_index'(g));
        assign hit_wb    = ls_wb & (ls_wb_idx == reg_index'(g));

        scoreboard_entry u_entry (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (flush),
            .load_cnt_i (hit_issue & ~issue_var),
            .load_val_i (issue_lat_eff),
            .set_ld_i   (hit_issue & issue_var),
            .clr_ld_i   (hit_wb),
            .busy_o     (busy_vec[g]),
            .ld_o       (ld_vec[g])
        );
    end

    always_comb begin
        hold_data = dst_valid & busy_vec[dst_idx];
        for (int k = 0; k < 3; k++) begin
            if (src_valid[k] && busy_vec[src_idx[k]]) begin
                hold_data = 1'b1;
            end
        end
    end

    assign loads_pending = |ld_vec;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic against a cycle-timestamp reference model.
module tb_hazard_scoreboard;

`ifdef HAZARD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic       clk;
  logic       reset;
  logic       issue;
  logic       issue_dst_valid;
  logic [4:0] issue_dst;
  logic [2:0] issue_lat;
  logic [2:0] src_valid;
  logic [4:0] src_idx [3];
  logic       dst_valid;
  logic [4:0] dst_idx;
  logic       ls_wb;
  logic [4:0] ls_wb_idx;
  logic       flush;
  logic       hold_data;
  logic       loads_pending;

  int total = 0;
  int bad = 0;

  // reference model: a register is busy until the cycle its result is ready
  int cyc = 0;
  int ready_at [32];
  bit ld_m [32];

  hazard_scoreboard dut (
    .clk             (clk),
    .reset           (reset),
    .issue           (issue),
    .issue_dst_valid (issue_dst_valid),
    .issue_dst       (issue_dst),
    .issue_lat       (issue_lat),
    .src_valid       (src_valid),
    .src_idx         (src_idx),
    .dst_valid       (dst_valid),
    .dst_idx         (dst_idx),
    .ls_wb           (ls_wb),
    .ls_wb_idx       (ls_wb_idx),
    .flush           (flush),
    .hold_data       (hold_data),
    .loads_pending   (loads_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_busy(int r);
    return ld_m[r] || (cyc < ready_at[r] - BYP);
  endfunction

  function automatic bit m_hold();
    bit h = 1'b0;
    for (int k = 0; k < 3; k++)
      if (src_valid[k] && m_busy(int'(src_idx[k]))) h = 1'b1;
    if (dst_valid && m_busy(int'(dst_idx))) h = 1'b1;
    return h;
  endfunction

  function automatic bit m_lp();
    bit p = 1'b0;
    for (int r = 0; r < 32; r++) if (ld_m[r]) p = 1'b1;
    return p;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; issue = 1'b0; issue_dst_valid = 1'b0; issue_dst = '0; issue_lat = '0;
    src_valid = '0; src_idx[0] = '0; src_idx[1] = '0; src_idx[2] = '0;
    dst_valid = 1'b0; dst_idx = '0; ls_wb = 1'b0; ls_wb_idx = '0; flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      ready_at[r] = 0;
      ld_m[r] = 1'b0;
    end
  endtask

  // Inputs are already driven (at negedge). Check outputs, advance one edge.
  task automatic step(input string tag, input bit use_exp, input bit eh, input bit elp);
    bit mh;
    bit acc;
    #1;
    mh = m_hold();
    chk({tag, "_hold_model"}, hold_data, mh);
    chk({tag, "_lp_model"}, loads_pending, m_lp());
    if (use_exp) begin
      chk({tag, "_hold"}, hold_data, eh);
      chk({tag, "_lp"}, loads_pending, elp);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      acc = issue && issue_dst_valid && !mh;
      if (flush) for (int r = 0; r < 32; r++) ready_at[r] = 0;
      if (acc && issue_lat != 0 && !flush) ready_at[issue_dst] = cyc + int'(issue_lat) + 1;
      if (ls_wb) ld_m[ls_wb_idx] = 1'b0;
      if (acc && issue_lat == 0) ld_m[issue_dst] = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_issue(input int r, input int lat);
    issue = 1'b1; issue_dst_valid = 1'b1; issue_dst = 5'(r); issue_lat = 3'(lat);
  endtask

  initial begin
    model_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step("reset", 1'b1, 1'b0, 1'b0);
    idle();
    step("after_reset", 1'b1, 1'b0, 1'b0);

    // fixed-latency producer r5 lat=3, consumer reads r5
    do_issue(5, 3);
    step("r5_issue", 1'b1, 1'b0, 1'b0);
    idle();
    src_valid[0] = 1'b1; src_idx[0] = 5'd5;
    for (int k = 0; k < 4; k++) step($sformatf("r5_read%0d", k), 1'b1, k < 3 - BYP, 1'b0);

    // variable-latency r7 held until ls_wb
    idle();
    do_issue(7, 0);
    step("r7_issue", 1'b1, 1'b0, 1'b0);
    idle();
    src_valid[1] = 1'b1; src_idx[1] = 5'd7;
    for (int k = 0; k < 5; k++) step($sformatf("r7_wait%0d", k), 1'b1, 1'b1, 1'b1);
    ls_wb = 1'b1; ls_wb_idx = 5'd7;
    step("r7_wb", 1'b1, 1'b1, 1'b1);
    ls_wb = 1'b0;
    step("r7_done", 1'b1, 1'b0, 1'b0);

    // flush cancels r3 but load on r8 survives
    idle();
    do_issue(8, 0);
    step("r8_issue", 1'b1, 1'b0, 1'b0);
    do_issue(3, 5);
    step("r3_issue", 1'b1, 1'b0, 1'b1);
    idle();
    flush = 1'b1;
    step("flush", 1'b1, 1'b0, 1'b1);
    idle();
    src_valid[2] = 1'b1; src_idx[2] = 5'd3;
    step("r3_after_flush", 1'b1, 1'b0, 1'b1);
    dst_valid = 1'b1; dst_idx = 5'd8;
    step("r8_survives", 1'b1, 1'b1, 1'b1);
    idle();
    ls_wb = 1'b1; ls_wb_idx = 5'd8;
    step("r8_wb", 1'b1, 1'b0, 1'b1);

    // same-cycle ls_wb and new load to r9: load wins
    idle();
    do_issue(9, 0);
    ls_wb = 1'b1; ls_wb_idx = 5'd9;
    step("r9_race", 1'b1, 1'b0, 1'b0);
    idle();
    src_valid[0] = 1'b1; src_idx[0] = 5'd9;
    step("r9_busy", 1'b1, 1'b1, 1'b1);
    idle();
    ls_wb = 1'b1; ls_wb_idx = 5'd9;
    step("r9_wb", 1'b1, 1'b0, 1'b1);

    // issue while stalled is ignored
    idle();
    do_issue(2, 6);
    step("r2_issue", 1'b1, 1'b0, 1'b0);
    do_issue(4, 6);
    src_valid[0] = 1'b1; src_idx[0] = 5'd2;
    step("r4_stalled", 1'b1, 1'b1, 1'b0);
    idle();
    dst_valid = 1'b1; dst_idx = 5'd4;
    step("r4_not_busy", 1'b1, 1'b0, 1'b0);

    // reset mid-operation discards pending state
    idle();
    do_issue(1, 5);
    step("r1_issue", 1'b1, 1'b0, 1'b0);
    do_issue(10, 0);
    step("r10_issue", 1'b1, 1'b0, 1'b0);
    idle();
    reset = 1'b1;
    src_valid[0] = 1'b1; src_idx[0] = 5'd1;
    src_valid[1] = 1'b1; src_idx[1] = 5'd10;
    step("mid_reset", 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    step("post_reset", 1'b1, 1'b0, 1'b0);

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      idle();
      reset = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      issue = $urandom_range(0, 1);
      issue_dst_valid = ($urandom_range(0, 3) != 0);
      issue_dst = 5'($urandom_range(0, 7));
      issue_lat = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        src_valid[k] = ($urandom_range(0, 2) == 0);
        src_idx[k] = 5'($urandom_range(0, 7));
      end
      dst_valid = ($urandom_range(0, 3) == 0);
      dst_idx = 5'($urandom_range(0, 7));
      ls_wb = ($urandom_range(0, 2) == 0);
      ls_wb_idx = 5'($urandom_range(0, 7));
      step("rand", 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
